// File: rtl/pwm_deadtime.sv
// Dead-time insertion: turns a single-ended PWM into a complementary high/low gate pair.
// Optional fault latching is compiled in with `define PWM_DT_FAULT_EN.
module pwm_deadtime #(
  parameter int unsigned DT_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pwm_in,
  input  logic            pwm_onoff,
  input  logic [DT_W-1:0] dt_rise,
  input  logic [DT_W-1:0] dt_fall,
`ifdef PWM_DT_FAULT_EN
  input  logic            fault,
  input  logic            fault_clr,
  output logic            fault_latched,
`endif
  output logic            pwm_h,
  output logic            pwm_l,
  output logic            dt_active,
  output logic [2:0]      state_o
);

  localparam logic PwmOn = 1'b1;

  typedef enum logic [2:0] {
    StOff  = 3'd0,
    StLow  = 3'd1,
    StDtLh = 3'd2,
    StHigh = 3'd3,
    StDtHl = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            pwm_h_q, pwm_h_d;
  logic            pwm_l_q, pwm_l_d;
  logic            dt_active_q, dt_active_d;
  logic            force_off;

`ifdef PWM_DT_FAULT_EN
  logic fault_q, fault_d;

  // Fault wins over a simultaneous clear.
  always_comb begin
    fault_d = fault_q;
    if (fault) begin
      fault_d = 1'b1;
    end else if (fault_clr) begin
      fault_d = 1'b0;
    end
  end

  assign force_off     = (pwm_onoff != PwmOn) | fault | fault_q;
  assign fault_latched = fault_q;
`else
  assign force_off = (pwm_onoff != PwmOn);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StOff;
      cnt_q       <= '0;
      pwm_h_q     <= 1'b0;
      pwm_l_q     <= 1'b0;
      dt_active_q <= 1'b0;
`ifdef PWM_DT_FAULT_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwm_h_q     <= pwm_h_d;
      pwm_l_q     <= pwm_l_d;
      dt_active_q <= dt_active_d;
`ifdef PWM_DT_FAULT_EN
      fault_q     <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (force_off) begin
      state_d = StOff;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          if (pwm_in) begin
            state_d = StDtLh;
            cnt_d   = dt_rise;
          end else begin
            state_d = StLow;
          end
        end
        StLow: begin
          if (pwm_in) begin
            state_d = StDtLh;
            cnt_d   = dt_rise;
          end
        end
        StDtLh: begin
          // An input that falls back before the count expires aborts with no pulse.
          if (!pwm_in) begin
            state_d = StLow;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = StHigh;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        StHigh: begin
          if (!pwm_in) begin
            state_d = StDtHl;
            cnt_d   = dt_fall;
          end
        end
        StDtHl: begin
          if (pwm_in) begin
            state_d = StHigh;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = StLow;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        default: begin
          state_d = StOff;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Decoding the next state into flops keeps the gates glitch-free and state-aligned.
  always_comb begin
    pwm_h_d     = (state_d == StHigh);
    pwm_l_d     = (state_d == StLow);
    dt_active_d = (state_d == StDtLh) || (state_d == StDtHl);
  end

  assign pwm_h     = pwm_h_q;
  assign pwm_l     = pwm_l_q;
  assign dt_active = dt_active_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed self-checking bench for pwm_deadtime; fault tests run when PWM_DT_FAULT_EN is defined.
module tb_pwm_deadtime;

  localparam int unsigned DT_W = 10;

  logic            clk;
  logic            reset;
  logic            pwm_in;
  logic            pwm_onoff;
  logic [DT_W-1:0] dt_rise;
  logic [DT_W-1:0] dt_fall;
  logic            pwm_h;
  logic            pwm_l;
  logic            dt_active;
  logic [2:0]      state_o;
`ifdef PWM_DT_FAULT_EN
  logic            fault;
  logic            fault_clr;
  logic            fault_latched;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;
  logic h_seen;

  pwm_deadtime #(.DT_W(DT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .pwm_in        (pwm_in),
    .pwm_onoff     (pwm_onoff),
    .dt_rise       (dt_rise),
    .dt_fall       (dt_fall),
`ifdef PWM_DT_FAULT_EN
    .fault         (fault),
    .fault_clr     (fault_clr),
    .fault_latched (fault_latched),
`endif
    .pwm_h         (pwm_h),
    .pwm_l         (pwm_l),
    .dt_active     (dt_active),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shoot-through guard, sampled away from the active edge.
  always @(negedge clk) begin
    check("no_overlap", {31'd0, pwm_h & pwm_l}, 32'd0);
  end

  initial begin
    reset     = 1'b1;
    pwm_in    = 1'b0;
    pwm_onoff = 1'b0;
    dt_rise   = 10'd5;
    dt_fall   = 10'd7;
`ifdef PWM_DT_FAULT_EN
    fault     = 1'b0;
    fault_clr = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b0;
    check("rst_state", state_o, 0);
    check("rst_h", pwm_h, 0);
    check("rst_l", pwm_l, 0);
    check("rst_dt", dt_active, 0);

    // Enable with input low: straight to LOW.
    pwm_onoff = 1'b1;
    tick();
    check("on_l", pwm_l, 1);
    check("on_h", pwm_h, 0);
    check("on_state", state_o, 1);

    // Rising with dt_rise=5; a mid-count change of dt_rise must not matter.
    pwm_in = 1'b1;
    tick();
    check("rise_l", pwm_l, 0);
    check("rise_h", pwm_h, 0);
    check("rise_state", state_o, 2);
    dt_rise = 10'd1;
    cnt = dt_active ? 1 : 0;
    for (int i = 0; i < 30 && !pwm_h; i++) begin
      tick();
      if (dt_active) cnt++;
    end
    check("rise_dt_clocks", cnt, 6);
    check("rise_high_h", pwm_h, 1);
    check("rise_high_state", state_o, 3);

    // Falling with dt_fall=7: eight both-low clocks.
    pwm_in = 1'b0;
    tick();
    check("fall_state", state_o, 4);
    cnt = (!pwm_h && !pwm_l) ? 1 : 0;
    for (int i = 0; i < 30 && !pwm_l; i++) begin
      tick();
      if (!pwm_h && !pwm_l) cnt++;
    end
    check("fall_lowlow_clocks", cnt, 8);
    check("fall_l", pwm_l, 1);
    check("fall_low_state", state_o, 1);

    // Zero dead time: one clock in each dead-time state.
    dt_rise = 10'd0;
    dt_fall = 10'd0;
    pwm_in  = 1'b1;
    tick();
    check("dt0_rise_state", state_o, 2);
    tick();
    check("dt0_high_h", pwm_h, 1);
    pwm_in = 1'b0;
    tick();
    check("dt0_fall_state", state_o, 4);
    tick();
    check("dt0_low_l", pwm_l, 1);

    // 3-clock pulse shorter than dt_rise=20: aborts back to LOW, no high-side pulse.
    dt_rise = 10'd20;
    h_seen  = 1'b0;
    pwm_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      h_seen |= pwm_h;
    end
    check("abort_in_dt", dt_active, 1);
    pwm_in = 1'b0;
    tick();
    check("abort_lh_state", state_o, 1);
    check("abort_lh_l", pwm_l, 1);
    for (int i = 0; i < 25; i++) begin
      tick();
      h_seen |= pwm_h;
    end
    check("abort_no_h", h_seen, 0);

    // Abort during DT_HL returns to HIGH.
    dt_rise = 10'd0;
    pwm_in  = 1'b1;
    tick();
    tick();
    check("pre_hl_h", pwm_h, 1);
    dt_fall = 10'd10;
    pwm_in  = 1'b0;
    tick();
    check("hl_dt_state", state_o, 4);
    pwm_in = 1'b1;
    tick();
    check("abort_hl_state", state_o, 3);
    check("abort_hl_h", pwm_h, 1);

    // PWM_OFF during HIGH forces both low on the next clock.
    pwm_onoff = 1'b0;
    tick();
    check("off_h", pwm_h, 0);
    check("off_l", pwm_l, 0);
    check("off_state", state_o, 0);
    tick();
    check("off_hold", state_o, 0);

    // Re-enable with input high: OFF -> DT_LH with dt_rise=2, HIGH after 3 clocks.
    dt_rise   = 10'd2;
    pwm_onoff = 1'b1;
    tick();
    check("off_to_dtlh", state_o, 2);
    tick();
    tick();
    check("off_dtlh_h_early", pwm_h, 0);
    tick();
    check("off_dtlh_h", pwm_h, 1);

    // Reset mid dead-time.
    dt_fall = 10'd9;
    pwm_in  = 1'b0;
    tick();
    check("pre_rst_dt", dt_active, 1);
    reset = 1'b1;
    tick();
    check("midrst_state", state_o, 0);
    check("midrst_dt", dt_active, 0);
    check("midrst_l", pwm_l, 0);
    reset = 1'b0;
    tick();
    check("post_rst_low", state_o, 1);

`ifdef PWM_DT_FAULT_EN
    dt_rise = 10'd0;
    pwm_in  = 1'b1;
    tick();
    tick();
    check("flt_pre_h", pwm_h, 1);
    fault = 1'b1;
    tick();
    fault = 1'b0;
    check("flt_state", state_o, 0);
    check("flt_latched", fault_latched, 1);
    check("flt_h", pwm_h, 0);
    h_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      h_seen |= pwm_h | pwm_l;
    end
    check("flt_hold_outputs", h_seen, 0);
    check("flt_hold_state", state_o, 0);
    fault     = 1'b1;
    fault_clr = 1'b1;
    tick();
    check("flt_wins", fault_latched, 1);
    fault = 1'b0;
    tick();
    fault_clr = 1'b0;
    check("flt_cleared", fault_latched, 0);
    check("flt_clr_off", state_o, 0);
    tick();
    check("flt_resume", state_o, 2);
    tick();
    check("flt_resume_h", pwm_h, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
